simple_named_block: RTL and testbench
=====================================

# simple_named_block

Free-running cycle counter with a nested, independently scoped modulo sub-counter. The design-level counter is a module-scope variable `i`. The sub-counter is a variable also named `i`, declared locally inside a named block `loop`. Both remain hierarchically visible as `<inst>.i` and `<inst>.loop.i`. The block is the reference example for declaration-space scoping and serves as a cycle/phase tick source in small test systems.

## Interface
Parameters:
- `WIDTH`, default 32: width of module-scope counter `i` and `count`.
- `LOOP_N`, default 4: modulus of `loop.i`; legal range is ≥1.
- `WRAP_W`, default 16: width of `wrap_count`.

Ports:
- `clock`, input, 1: sole clock; all state updates on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset. Port default is `1'b1`, so an instance with only `clock` connected runs.
- `enable`, input, 1: advances both counters when high. Port default is `1'b1`.
- `count`, output, `WIDTH`: mirrors module-scope `i`.
- `loop_count`, output, `LW = max(1, $clog2(LOOP_N))`: mirrors `loop.i`.
- `loop_wrap`, output, 1: registered one-cycle pulse on the edge where `loop.i` wraps to 0.
- `wrap_count`, output, `WRAP_W`: number of `loop` wraps since reset.

## Operation
- Module scope declares `logic [WIDTH-1:0] i`, with an initializer of 0.
- Named block `loop` declares its own `logic [LW-1:0] i`, with an initializer of 0. This shadows the outer `i` inside the block.
  - Inside `loop`, the outer counter is referenced only hierarchically.
  - Both are static and readable from the bench by hierarchical path.
- When `reset_n` is low: `i`, `loop.i`, `loop_wrap` and `wrap_count` are 0 immediately, with no clock required.
- On each rising edge with `enable=1`:
  - `i <= i + 1`, wrapping modulo 2^WIDTH.
  - If `loop.i == LOOP_N-1`: `loop.i <= 0`, `loop_wrap <= 1`, `wrap_count <= wrap_count + 1` (wrapping).
  - Otherwise: `loop.i <= loop.i + 1`, `loop_wrap <= 0`.
- On each rising edge with `enable=0`:
  - All counters hold.
  - `loop_wrap <= 0`.
- `LOOP_N=1`: `loop.i` is constantly 0, and `loop_wrap` is 1 after every enabled edge.
- Initializers guarantee deterministic counts from time 0 when `reset_n` is never asserted.

## Timing
- All outputs are registered, with one-edge latency from `enable`.
- `count` equals the number of enabled rising edges since the last reset release, modulo 2^WIDTH.
- `loop_count` equals `count mod LOOP_N` whenever `LOOP_N` is a power of two and `WIDTH` ≥ `LW`.
- Reset assertion mid-count clears all state asynchronously, at the reset edge rather than the next clock.
- Reset release coincident with a clock edge: that edge does not count.
- `loop_wrap` is high exactly one cycle per wrap, or continuously for `LOOP_N=1`.

## Configuration
- Macro `SIMPLE_WRAP_COUNT_EN`.
- When defined: the `wrap_count` register and incrementer are built.
- When undefined: `wrap_count` is tied to 0 and no register is synthesized. `loop_wrap` is unaffected.

## Structure
- Package `simple_named_block_pkg` holds:
  - default constants `SIMPLE_WIDTH=32`, `SIMPLE_LOOP_N=4` and `SIMPLE_WRAP_W=16`;
  - function `loop_w(n)`, returning `max(1, $clog2(n))`.
- No sub-module. The named block `loop` is the scoping unit, and the hierarchical path `loop.i` must exist exactly as named. Do not move it into a child instance.

## Test plan
- `reset_n` is left at its default. Clock period is 10, starting low with the first rising edge at t=5. Wait 5 falling edges, then 10 time units (t=60). Require `i=6`, `loop.i=2`, `count=6`, `loop_count=2`.
- Run 8 enabled edges from reset. Require `loop_wrap` pulses after edges 4 and 8, and `wrap_count=2`.
- Deassert `enable` for 3 edges at `count=5`. Require `count`/`loop.i` to hold at 5/1 and `loop_wrap=0`.
- Assert `reset_n=0` between clock edges at `count=7`. Require all outputs 0 before the next edge. On release, require `count=1` after the first subsequent edge.
- `WIDTH=3`: after 9 edges, require `count=1`, showing wrap-around.
- Build without `SIMPLE_WRAP_COUNT_EN`: after 12 edges, require `wrap_count=0` and `loop_wrap` pulses still present.

Source files
------------

// File: rtl/simple_named_block_pkg.sv
// Shared default constants and the loop-counter width helper for simple_named_block.
package simple_named_block_pkg;

   localparam int SIMPLE_WIDTH  = 32;
   localparam int SIMPLE_LOOP_N = 4;
   localparam int SIMPLE_WRAP_W = 16;

   // Width of the loop sub-counter: $clog2(n), but never narrower than one bit.
   function automatic int loop_w(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/simple_named_block.sv
// Free-running cycle counter with a shadowing modulo sub-counter in named scope `loop`.
// Define SIMPLE_WRAP_COUNT_EN to build the wrap_count register; otherwise it reads 0.
module simple_named_block
   import simple_named_block_pkg::*;
#(
   parameter int WIDTH   = SIMPLE_WIDTH,
   parameter int LOOP_N  = SIMPLE_LOOP_N,
   parameter int WRAP_W  = SIMPLE_WRAP_W,
   localparam int LW     = loop_w(LOOP_N)
)(
   input  logic              clock,
   input  logic              reset_n = 1'b1,
   input  logic              enable  = 1'b1,
   output logic [WIDTH-1:0]  count,
   output logic [LW-1:0]     loop_count,
   output logic              loop_wrap,
   output logic [WRAP_W-1:0] wrap_count
);

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1'b1);

   logic [WIDTH-1:0] i = {WIDTH{1'b0}};

   // Module-scope cycle counter, advancing on every enabled edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         i <= {WIDTH{1'b0}};
      end else if (enable) begin
         i <= i + ONE_W;
      end else begin
         i <= i;
      end
   end

   // Inside this scope `i` is the local sub-counter and shadows the outer counter.
   if (1'b1) begin : loop
      localparam logic [LW-1:0] LAST  = LW'(LOOP_N - 1);
      localparam logic [LW-1:0] ONE_L = LW'(1'b1);

      logic [LW-1:0] i    = {LW{1'b0}};
      logic          wrap = 1'b0;

      // Modulo-LOOP_N sub-counter and its registered wrap pulse.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            i    <= {LW{1'b0}};
            wrap <= 1'b0;
         end else if (enable) begin
            if (i == LAST) begin
               i    <= {LW{1'b0}};
               wrap <= 1'b1;
            end else begin
               i    <= i + ONE_L;
               wrap <= 1'b0;
            end
         end else begin
            i    <= i;
            wrap <= 1'b0;
         end
      end

`ifdef SIMPLE_WRAP_COUNT_EN
      localparam logic [WRAP_W-1:0] ONE_C = WRAP_W'(1'b1);

      logic [WRAP_W-1:0] wraps = {WRAP_W{1'b0}};

      // Counts sub-counter wraps since reset, wrapping modulo 2^WRAP_W.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            wraps <= {WRAP_W{1'b0}};
         end else if (enable && (i == LAST)) begin
            wraps <= wraps + ONE_C;
         end else begin
            wraps <= wraps;
         end
      end
`endif
   end

   assign count      = i;
   assign loop_count = loop.i;
   assign loop_wrap  = loop.wrap;

`ifdef SIMPLE_WRAP_COUNT_EN
   assign wrap_count = loop.wraps;
`else
   assign wrap_count = {WRAP_W{1'b0}};
`endif

endmodule

// File: tb/tb_simple_named_block.sv
// Directed self-checking bench for simple_named_block; wrap_count expectations follow SIMPLE_WRAP_COUNT_EN.
module tb_simple_named_block;
   import simple_named_block_pkg::*;

`ifdef SIMPLE_WRAP_COUNT_EN
   localparam int WRAP_EN = 1;
`else
   localparam int WRAP_EN = 0;
`endif

   logic        clk      = 1'b0;
   logic        rst_main = 1'b1;
   logic        en_main  = 1'b1;
   logic [31:0] count;
   logic [1:0]  loop_count;
   logic        loop_wrap;
   logic [15:0] wrap_count;

   logic        rst_aux  = 1'b0;
   logic        en_aux   = 1'b1;
   logic [2:0]  aux_count;
   logic [0:0]  aux_loop;
   logic        aux_wrap;
   logic [15:0] aux_wraps;

   int checks = 0;
   int passes = 0;

   simple_named_block dut (
      .clock      (clk),
      .reset_n    (rst_main),
      .enable     (en_main),
      .count      (count),
      .loop_count (loop_count),
      .loop_wrap  (loop_wrap),
      .wrap_count (wrap_count)
   );

   simple_named_block #(.WIDTH(3), .LOOP_N(1), .WRAP_W(16)) dut_aux (
      .clock      (clk),
      .reset_n    (rst_aux),
      .enable     (en_aux),
      .count      (aux_count),
      .loop_count (aux_loop),
      .loop_wrap  (aux_wrap),
      .wrap_count (aux_wraps)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      // Free run from time 0 with reset never asserted: six rising edges by t=60.
      repeat (5) @(negedge clk);
      #10;
      check_value("free_i",          dut.i,      32'd6);
      check_value("free_loop_i",     dut.loop.i, 32'd2);
      check_value("free_count",      count,      32'd6);
      check_value("free_loop_count", loop_count, 32'd2);

      // Asynchronous reset between edges clears everything without a clock.
      rst_main = 1'b0;
      #1;
      check_value("rst_count",      count,      32'd0);
      check_value("rst_loop_count", loop_count, 32'd0);
      check_value("rst_loop_wrap",  loop_wrap,  32'd0);
      check_value("rst_wrap_count", wrap_count, 32'd0);
      @(negedge clk);
      rst_main = 1'b1;

      // Twelve enabled edges: wrap pulses after edges 4, 8 and 12 only.
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check_value($sformatf("wrap_edge%0d", k), loop_wrap, ((k % 4) == 0) ? 32'd1 : 32'd0);
      end
      check_value("run12_count",      count,      32'd12);
      check_value("run12_loop_count", loop_count, 32'd0);
      check_value("run12_wrap_count", wrap_count, (WRAP_EN != 0) ? 32'd3 : 32'd0);

      // Hold at count 5 while enable is low.
      rst_main = 1'b0;
      @(negedge clk);
      rst_main = 1'b1;
      repeat (5) @(negedge clk);
      check_value("pre_hold_count", count, 32'd5);
      en_main = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check_value($sformatf("hold%0d_count", k),  count,      32'd5);
         check_value($sformatf("hold%0d_loop_i", k), dut.loop.i, 32'd1);
         check_value($sformatf("hold%0d_wrap", k),   loop_wrap,  32'd0);
      end
      en_main = 1'b1;

      // Reach 7, then reset mid-cycle and release; first edge after release gives 1.
      repeat (2) @(negedge clk);
      check_value("pre_rst_count", count, 32'd7);
      #2;
      rst_main = 1'b0;
      #1;
      check_value("mid_rst_count",      count,      32'd0);
      check_value("mid_rst_loop_count", loop_count, 32'd0);
      check_value("mid_rst_loop_wrap",  loop_wrap,  32'd0);
      check_value("mid_rst_wrap_count", wrap_count, 32'd0);
      @(negedge clk);
      check_value("held_rst_count", count, 32'd0);
      rst_main = 1'b1;
      @(negedge clk);
      check_value("post_rel_count", count, 32'd1);

      // WIDTH=3, LOOP_N=1 instance: count wraps mod 8, wrap pulse on every edge.
      rst_aux = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         check_value($sformatf("aux_wrap%0d", k), aux_wrap, 32'd1);
      end
      check_value("aux_count",      aux_count, 32'd1);
      check_value("aux_loop_count", aux_loop,  32'd0);
      check_value("aux_wrap_count", aux_wraps, (WRAP_EN != 0) ? 32'd9 : 32'd0);
      en_aux = 1'b0;
      @(negedge clk);
      check_value("aux_idle_wrap",  aux_wrap,  32'd0);
      check_value("aux_idle_count", aux_count, 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
